// File: rtl/mavg_pkg.sv
// mavg_pkg
//    Shared sizing helpers and parameter limits for the moving-average
//    decimator (mavg_decimator) and its history ring (mavg_hist_ring).
//    No ports; import with "import mavg_pkg::*;".
package mavg_pkg;

   localparam int MIN_DATA_W    = 2;
   localparam int MAX_LOG2_TAPS = 6;
   localparam int MIN_DECIM     = 1;
   localparam int MAX_DECIM     = 256;

   // The running sum of TAPS signed DATA_W samples needs LOG2_TAPS extra bits.
   function automatic int acc_width(input int data_w, input int log2_taps);
      return data_w + log2_taps;
   endfunction

   // A one-entry ring still needs a one-bit pointer port; it is held at 0.
   function automatic int ptr_width(input int log2_taps);
      return (log2_taps > 0) ? log2_taps : 1;
   endfunction

   function automatic int cnt_width(input int decim);
      return (decim > 1) ? $clog2(decim) : 1;
   endfunction

   function automatic bit params_legal(input int data_w, input int log2_taps,
                                       input int decim, input int round_mode);
      return (data_w >= MIN_DATA_W) &&
             (log2_taps >= 0) && (log2_taps <= MAX_LOG2_TAPS) &&
             (decim >= MIN_DECIM) && (decim <= MAX_DECIM) &&
             ((round_mode == 0) || (round_mode == 1));
   endfunction

endpackage

// File: rtl/mavg_hist_ring.sv
// mavg_hist_ring
//    TAPS x DATA_W circular history buffer. rd_data always shows the entry at
//    wr_ptr (the oldest sample, about to be overwritten); when we=1 that entry
//    is replaced by wr_data on the clock edge. clr zeroes every entry.
// Ports:
//    clk, rst_n       clock, asynchronous active-low reset
//    clr              synchronous clear of all entries (wins over we)
//    we               write wr_data at wr_ptr
//    wr_ptr           entry to read (old) and write (new)
//    wr_data          sample to store
//    rd_data          current contents of entry wr_ptr
module mavg_hist_ring
   import mavg_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int LOG2_TAPS = 2,
   parameter int PTR_W     = ptr_width(LOG2_TAPS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     we,
   input  logic [PTR_W-1:0]         wr_ptr,
   input  logic signed [DATA_W-1:0] wr_data,
   output logic signed [DATA_W-1:0] rd_data
);

   localparam int TAPS = 1 << LOG2_TAPS;

   logic signed [DATA_W-1:0] mem_q [TAPS];
   logic signed [DATA_W-1:0] mem_d [TAPS];

   // Next-state of the buffer: clear everything, or overwrite the oldest entry.
   always_comb begin
      mem_d = mem_q;
      if (clr) begin
         for (int i = 0; i < TAPS; i++) begin
            mem_d[i] = '0;
         end
      end else if (we) begin
         mem_d[wr_ptr] = wr_data;
      end
   end

   // History storage; reset brings every entry back to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[wr_ptr];

endmodule

// File: rtl/mavg_decimator.sv
// mavg_decimator
//    Boxcar moving average over TAPS = 2**LOG2_TAPS samples followed by
//    decimation by DECIM, with optional round-half-up before the final shift.
//    The running sum is kept incrementally: add the new sample, subtract the
//    one leaving the window (read from the history ring).
// Ports:
//    clk, rst_n   clock, asynchronous active-low reset
//    clr          synchronous clear of history, sum and counters (drops in_data)
//    in_valid/in_ready/in_data     input sample handshake
//    out_valid/out_ready/out_data  averaged, decimated result handshake
//    out_warm     result came from a full window of real samples
module mavg_decimator
   import mavg_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int LOG2_TAPS = 2,
   parameter int DECIM     = 2,
   parameter int ROUND     = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_warm
);

   localparam int TAPS    = 1 << LOG2_TAPS;
   localparam int AW      = acc_width(DATA_W, LOG2_TAPS);
   localparam int PW      = ptr_width(LOG2_TAPS);
   localparam int CW      = cnt_width(DECIM);
   localparam int FW      = LOG2_TAPS + 1;
   localparam int RND_OFS = (ROUND != 0) ? (TAPS / 2) : 0;

   if (!params_legal(DATA_W, LOG2_TAPS, DECIM, ROUND)) begin : g_illegal_params
      $error("mavg_decimator: illegal parameter combination");
   end

   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]            dec_cnt_q, dec_cnt_d;
   logic [FW-1:0]            fill_q, fill_d;
   logic signed [AW-1:0]     acc_q, acc_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;
   logic                     out_warm_q, out_warm_d;

   logic signed [DATA_W-1:0] hist_old;
   logic signed [AW-1:0]     acc_n;
   logic signed [AW-1:0]     rounded;
   logic                     accept;
   logic                     last_phase;

   // Any held result blocks intake, even for samples that would not produce
   // an output, so the window never advances past an unread result.
   assign in_ready   = !clr && !(out_valid_q && !out_ready);
   assign accept     = in_valid && in_ready;
   assign last_phase = (dec_cnt_q == CW'(DECIM - 1));

   assign acc_n   = acc_q + AW'(in_data) - AW'(hist_old);
   assign rounded = acc_n + AW'(RND_OFS);

   mavg_hist_ring #(
      .DATA_W    (DATA_W),
      .LOG2_TAPS (LOG2_TAPS),
      .PTR_W     (PW)
   ) u_hist (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .we      (accept),
      .wr_ptr  (wr_ptr_q),
      .wr_data (in_data),
      .rd_data (hist_old)
   );

   // Next-state for sum, pointers and output register. clr beats everything
   // but leaves out_data/out_warm as they were; a load in the same cycle as a
   // consume keeps out_valid high so one result per DECIM samples streams.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      dec_cnt_d   = dec_cnt_q;
      fill_d      = fill_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_warm_d  = out_warm_q;
      if (clr) begin
         wr_ptr_d    = '0;
         dec_cnt_d   = '0;
         fill_d      = '0;
         acc_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         if (accept) begin
            acc_d     = acc_n;
            wr_ptr_d  = (TAPS == 1) ? '0 : wr_ptr_q + PW'(1);
            dec_cnt_d = last_phase ? '0 : dec_cnt_q + CW'(1);
            fill_d    = (fill_q == FW'(TAPS)) ? fill_q : fill_q + FW'(1);
         end
         if (accept && last_phase) begin
            out_data_d  = DATA_W'(rounded >>> LOG2_TAPS);
            out_warm_d  = (fill_d == FW'(TAPS));
            out_valid_d = 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State registers; reset discards any pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         dec_cnt_q   <= '0;
         fill_q      <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_warm_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         dec_cnt_q   <= dec_cnt_d;
         fill_q      <= fill_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_warm_q  <= out_warm_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_warm  = out_warm_q;

endmodule

// File: tb/tb_mavg_decimator.sv
// tb_mavg_decimator
//    Drives four differently-parameterised mavg_decimator instances from one
//    shared input stream and compares each against a window/average model.
module tb_mavg_decimator;

   localparam int NI = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   logic in_valid;
   logic out_ready;
   logic signed [15:0] in_data;

   logic               rdy_w [NI];
   logic               vld_w [NI];
   logic               wrm_w [NI];
   logic signed [15:0] dat_w [NI];

   int n_checks = 0;
   int n_fail   = 0;

   int samp [NI][$];
   int cnt     [NI];
   bit m_valid [NI];
   int m_data  [NI];
   bit m_warm  [NI];

   typedef struct {
      logic v;
      int   d;
      logic ordy;
      logic ev;
      int   ed;
      logic ew;
   } vec_t;

   vec_t t1 [9];

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   mavg_decimator #(.DATA_W(16), .LOG2_TAPS(2), .DECIM(2), .ROUND(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_w[0]),
      .in_data(in_data), .out_valid(vld_w[0]), .out_ready(out_ready),
      .out_data(dat_w[0]), .out_warm(wrm_w[0]));

   mavg_decimator #(.DATA_W(16), .LOG2_TAPS(2), .DECIM(4), .ROUND(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_w[1]),
      .in_data(in_data), .out_valid(vld_w[1]), .out_ready(out_ready),
      .out_data(dat_w[1]), .out_warm(wrm_w[1]));

   mavg_decimator #(.DATA_W(16), .LOG2_TAPS(2), .DECIM(4), .ROUND(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_w[2]),
      .in_data(in_data), .out_valid(vld_w[2]), .out_ready(out_ready),
      .out_data(dat_w[2]), .out_warm(wrm_w[2]));

   mavg_decimator #(.DATA_W(16), .LOG2_TAPS(0), .DECIM(1), .ROUND(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy_w[3]),
      .in_data(in_data), .out_valid(vld_w[3]), .out_ready(out_ready),
      .out_data(dat_w[3]), .out_warm(wrm_w[3]));

   function automatic int tapsOf(input int i);
      return (i == 3) ? 1 : 4;
   endfunction

   function automatic int decOf(input int i);
      case (i)
         0:       return 2;
         3:       return 1;
         default: return 4;
      endcase
   endfunction

   function automatic bit rndOf(input int i);
      return (i != 2);
   endfunction

   function automatic int floorDiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < NI; i++) begin
         samp[i].delete();
         cnt[i]     = 0;
         m_valid[i] = 1'b0;
         m_data[i]  = 0;
         m_warm[i]  = 1'b0;
      end
   endtask

   // Average of the last TAPS real samples (missing ones count as zero),
   // produced on every DECIM-th accepted sample since reset/clear.
   task automatic modelStep(input int i, input bit accept, input int d, input bit c, input bit ordy);
      int sum;
      int q;
      if (c) begin
         samp[i].delete();
         cnt[i]     = 0;
         m_valid[i] = 1'b0;
      end else if (accept) begin
         samp[i].push_back(d);
         if (samp[i].size() > tapsOf(i)) void'(samp[i].pop_front());
         cnt[i]++;
         if (cnt[i] % decOf(i) == 0) begin
            sum = 0;
            for (int k = 0; k < samp[i].size(); k++) sum += samp[i][k];
            q = floorDiv(sum + (rndOf(i) ? tapsOf(i) / 2 : 0), tapsOf(i));
            assert (q >= -32768 && q <= 32767)
               else $error("[TB] model result %0d exceeds 16-bit range", q);
            m_data[i]  = q;
            m_warm[i]  = (cnt[i] >= tapsOf(i));
            m_valid[i] = 1'b1;
         end else if (m_valid[i] && ordy) begin
            m_valid[i] = 1'b0;
         end
      end else if (m_valid[i] && ordy) begin
         m_valid[i] = 1'b0;
      end
   endtask

   // One clock of stimulus: drive after the falling edge, check in_ready,
   // then check every instance's outputs 1 time unit after the rising edge.
   task automatic applyStimulus(input logic v, input int d, input logic c, input logic ordy);
      bit acc [NI];
      bit exp_rdy;
      @(negedge clk);
      in_valid  = v;
      in_data   = d[15:0];
      clr       = c;
      out_ready = ordy;
      #1;
      for (int i = 0; i < NI; i++) begin
         exp_rdy = !c && !(m_valid[i] && !ordy);
         checkOutput($sformatf("in_ready[%0d]", i), int'(rdy_w[i]), int'(exp_rdy));
         acc[i] = v && exp_rdy;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         modelStep(i, acc[i], d, c, ordy);
         checkOutput($sformatf("out_valid[%0d]", i), int'(vld_w[i]), int'(m_valid[i]));
         if (m_valid[i]) begin
            checkOutput($sformatf("out_data[%0d]", i), int'(dat_w[i]), m_data[i]);
            checkOutput($sformatf("out_warm[%0d]", i), int'(wrm_w[i]), int'(m_warm[i]));
         end
      end
   endtask

   // Reset asserted between clock edges so the output clear must be asynchronous.
   task automatic doReset();
      @(negedge clk);
      #2;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      #1;
      modelReset();
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("rst_valid[%0d]", i), int'(vld_w[i]), 0);
         checkOutput($sformatf("rst_data[%0d]", i), int'(dat_w[i]), 0);
         checkOutput($sformatf("rst_warm[%0d]", i), int'(wrm_w[i]), 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic feedN(input int d, input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b1, d, 1'b0, 1'b1);
   endtask

   function automatic int randSample();
      logic [15:0] r;
      case ($urandom_range(0, 7))
         0:       return 32767;
         1:       return -32768;
         default: begin
            r = 16'($urandom);
            return int'($signed(r));
         end
      endcase
   endfunction

   // Watchdog so the run always ends even if the bench stalls.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int held;
      rst_n     = 1'b0;
      clr       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      modelReset();

      // Steady 100 input, decimate by 2: expected results on instance 0.
      for (int k = 0; k < 8; k++) begin
         t1[k].v    = 1'b1;
         t1[k].d    = 100;
         t1[k].ordy = 1'b1;
         t1[k].ev   = (k % 2 == 1);
         t1[k].ed   = (k == 1) ? 50 : 100;
         t1[k].ew   = (k >= 3);
      end
      t1[8] = '{v: 1'b0, d: 0, ordy: 1'b1, ev: 1'b0, ed: 0, ew: 1'b0};

      doReset();
      for (int k = 0; k < 9; k++) begin
         applyStimulus(t1[k].v, t1[k].d, 1'b0, t1[k].ordy);
         checkOutput($sformatf("t1_valid_row%0d", k), int'(vld_w[0]), int'(t1[k].ev));
         if (t1[k].ev) begin
            checkOutput($sformatf("t1_data_row%0d", k), int'(dat_w[0]), t1[k].ed);
            checkOutput($sformatf("t1_warm_row%0d", k), int'(wrm_w[0]), int'(t1[k].ew));
         end
      end

      // Rounding vs truncation, then full-scale extremes, on the DECIM=4 instances.
      doReset();
      feedN(1, 3);
      feedN(0, 1);
      checkOutput("rnd_up_valid", int'(vld_w[1]), 1);
      checkOutput("rnd_up_data", int'(dat_w[1]), 1);
      checkOutput("rnd_trunc_data", int'(dat_w[2]), 0);
      feedN(-3, 4);
      checkOutput("rnd_neg_data", int'(dat_w[1]), -3);
      feedN(32767, 4);
      checkOutput("max_data_r1", int'(dat_w[1]), 32767);
      checkOutput("max_data_r0", int'(dat_w[2]), 32767);
      feedN(-32768, 4);
      checkOutput("min_data_r1", int'(dat_w[1]), -32768);
      checkOutput("min_data_r0", int'(dat_w[2]), -32768);

      // Backpressure: hold the first result for 10 clocks, then resume.
      doReset();
      applyStimulus(1'b1, randSample(), 1'b0, 1'b1);
      applyStimulus(1'b1, randSample(), 1'b0, 1'b1);
      held = m_data[0];
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, randSample(), 1'b0, 1'b0);
         checkOutput("bp_in_ready", int'(rdy_w[0]), 0);
         checkOutput("bp_data_hold", int'(dat_w[0]), held);
      end
      for (int k = 0; k < 40; k++) applyStimulus(1'b1, randSample(), 1'b0, 1'b1);

      // clr after three samples of 200 drops the sample presented with it.
      doReset();
      feedN(200, 3);
      applyStimulus(1'b1, 200, 1'b1, 1'b1);
      checkOutput("clr_valid", int'(vld_w[0]), 0);
      feedN(40, 2);
      checkOutput("clr_first_data", int'(dat_w[0]), 20);
      checkOutput("clr_first_warm", int'(wrm_w[0]), 0);
      feedN(40, 2);
      checkOutput("clr_second_data", int'(dat_w[0]), 40);
      checkOutput("clr_second_warm", int'(wrm_w[0]), 1);

      // Reset mid-window while a result is being held.
      doReset();
      feedN(8, 2);
      applyStimulus(1'b1, 8, 1'b0, 1'b0);
      checkOutput("prerst_valid", int'(vld_w[0]), 1);
      doReset();
      feedN(8, 2);
      checkOutput("postrst_valid", int'(vld_w[0]), 1);
      checkOutput("postrst_data", int'(dat_w[0]), 4);
      checkOutput("postrst_warm", int'(wrm_w[0]), 0);

      // Randomised traffic with occasional clr and one reset part-way.
      for (int k = 0; k < 1500; k++) begin
         if (k == 700) doReset();
         applyStimulus($urandom_range(0, 3) != 0, randSample(),
                       $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
